// File: rtl/obi_mgr.sv
// Single-outstanding OBI manager: latches one controller request, drives the A channel until grant, then collects the R response.
// Optional error response capture is enabled by defining OBI_MGR_ERR_RESP_EN.
module obi_mgr #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int AUSER_WIDTH = 0,
    parameter int WUSER_WIDTH = 0,
    parameter int RUSER_WIDTH = 0,
    parameter int ID_WIDTH    = 0,
    parameter int ACHK_WIDTH  = 0,
    parameter int RCHK_WIDTH  = 0,
    parameter int COMB_GNT    = 0
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rsp_o,
    output logic                    obi_req_o,
    input  logic                    obi_gnt_i,
    output logic [ADDR_WIDTH-1:0]   obi_addr_o,
    output logic                    obi_we_o,
    output logic [DATA_WIDTH/8-1:0] obi_be_o,
    output logic [DATA_WIDTH-1:0]   obi_wdata_o,
    input  logic                    obi_rvalid_i,
    output logic                    obi_rready_o,
    input  logic [DATA_WIDTH-1:0]   obi_rdata_i,
    input  logic                    obi_err_i
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        ADDR = 3'b001,
        RESP = 3'b010,
        DONE = 3'b011,
        ERR  = 3'b100
    } state_t;

    state_t state;
    state_t w_state_next;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [BE_WIDTH-1:0]   r_be;
    logic [DATA_WIDTH-1:0] r_rsp;

    logic w_fast;
    logic w_accept;
    logic w_resp_done;
    logic w_err;
    logic w_unused_cfg;

    // Fast path: in IDLE the controller request is presented straight to the bus.
    assign w_fast      = (COMB_GNT != 0) && (state == IDLE);
    assign w_accept    = (state == IDLE) && req_i;
    assign w_resp_done = (state == RESP) && obi_rvalid_i;

`ifdef OBI_MGR_ERR_RESP_EN
    assign w_err = obi_err_i;
`else
    assign w_err = 1'b0;
`endif

    assign w_unused_cfg = obi_err_i ^ (AUSER_WIDTH != 0) ^ (WUSER_WIDTH != 0) ^ (RUSER_WIDTH != 0)
                        ^ (ID_WIDTH != 0) ^ (ACHK_WIDTH != 0) ^ (RCHK_WIDTH != 0);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= IDLE;
        end else begin
            state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = state;
        case (state)
            IDLE: begin
                if (req_i) begin
                    w_state_next = (w_fast && obi_gnt_i) ? RESP : ADDR;
                end
            end
            ADDR: begin
                if (obi_gnt_i) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                if (obi_rvalid_i) begin
                    w_state_next = w_err ? ERR : DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            ERR:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rsp   <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= addr_i;
                r_we    <= we_i;
                r_wdata <= wdata_i;
                r_be    <= '1;
            end
            // Byte enables drop with the response so DONE/ERR/IDLE show none.
            if (w_resp_done) begin
                r_be <= '0;
                if (w_err) begin
                    r_rsp <= '1;
                end else if (!r_we) begin
                    r_rsp <= obi_rdata_i;
                end
            end
        end
    end

    assign obi_req_o    = (state == ADDR) || (w_fast && req_i);
    assign obi_addr_o   = w_fast ? addr_i  : r_addr;
    assign obi_we_o     = w_fast ? we_i    : r_we;
    assign obi_wdata_o  = w_fast ? wdata_i : r_wdata;
    assign obi_be_o     = w_fast ? {BE_WIDTH{req_i}} : r_be;
    assign obi_rready_o = (state == RESP);
    assign rsp_o        = r_rsp;

endmodule

// File: tb/tb_obi_mgr.sv
// Directed vector bench for obi_mgr: read, write, grant stall, wait in RESP, response error, async reset mid-transaction.
module tb_obi_mgr;

    logic        clk_i;
    logic        reset_ni;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rsp_o;
    logic        obi_req_o;
    logic        obi_gnt_i;
    logic [31:0] obi_addr_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_wdata_o;
    logic        obi_rvalid_i;
    logic        obi_rready_o;
    logic [31:0] obi_rdata_i;
    logic        obi_err_i;

    int n_checks = 0;
    int n_fail   = 0;

    obi_mgr dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rsp_o       (rsp_o),
        .obi_req_o   (obi_req_o),
        .obi_gnt_i   (obi_gnt_i),
        .obi_addr_o  (obi_addr_o),
        .obi_we_o    (obi_we_o),
        .obi_be_o    (obi_be_o),
        .obi_wdata_o (obi_wdata_o),
        .obi_rvalid_i(obi_rvalid_i),
        .obi_rready_o(obi_rready_o),
        .obi_rdata_i (obi_rdata_i),
        .obi_err_i   (obi_err_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        gnt;
        logic        rvalid;
        logic        err;
        logic [31:0] rdata;
        logic [2:0]  st;
        logic        oreq;
        logic        ordy;
        logic [31:0] oaddr;
        logic        owe;
        logic [31:0] owdata;
        logic [3:0]  obe;
        logic [31:0] orsp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic gnt, input logic rvalid, input logic err, input logic [31:0] rdata,
                       input logic [2:0] st, input logic oreq, input logic ordy, input logic [31:0] oaddr,
                       input logic owe, input logic [31:0] owdata, input logic [3:0] obe, input logic [31:0] orsp);
        vec_t v;
        v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
        v.gnt = gnt; v.rvalid = rvalid; v.err = err; v.rdata = rdata;
        v.st = st; v.oreq = oreq; v.ordy = ordy; v.oaddr = oaddr;
        v.owe = owe; v.owdata = owdata; v.obe = obe; v.orsp = orsp;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic gnt, input logic rvalid, input logic err, input logic [31:0] rdata);
        req_i = req; we_i = we; addr_i = addr; wdata_i = wdata;
        obi_gnt_i = gnt; obi_rvalid_i = rvalid; obi_err_i = err; obi_rdata_i = rdata;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " state"},  {29'd0, dut.state}, 32'd0);
        chk({tag, " req"},    {31'd0, obi_req_o}, 32'd0);
        chk({tag, " rready"}, {31'd0, obi_rready_o}, 32'd0);
        chk({tag, " addr"},   obi_addr_o, 32'd0);
        chk({tag, " we"},     {31'd0, obi_we_o}, 32'd0);
        chk({tag, " wdata"},  obi_wdata_o, 32'd0);
        chk({tag, " be"},     {28'd0, obi_be_o}, 32'd0);
        chk({tag, " rsp"},    rsp_o, 32'd0);
    endtask

    logic [2:0]  exp_err_st;
    logic [31:0] exp_err_rsp;

    initial begin
`ifdef OBI_MGR_ERR_RESP_EN
        exp_err_st  = 3'b100;
        exp_err_rsp = 32'hFFFF_FFFF;
`else
        exp_err_st  = 3'b011;
        exp_err_rsp = 32'h7777_7777;
`endif
        //   req we addr          wdata         gnt rv err rdata         st    oreq rdy oaddr        owe owdata        be    rsp
        // read
        add(1, 0, 32'hDEADBEEF, 32'h0,        0, 0, 0, 32'h0,        3'd1, 1, 0, 32'hDEADBEEF, 0, 32'h0,        4'hF, 32'h0);
        add(0, 0, 32'h0,        32'h0,        1, 0, 0, 32'h0,        3'd2, 0, 1, 32'hDEADBEEF, 0, 32'h0,        4'hF, 32'h0);
        add(0, 0, 32'h0,        32'h0,        0, 1, 0, 32'h12345678, 3'd3, 0, 0, 32'hDEADBEEF, 0, 32'h0,        4'h0, 32'h12345678);
        add(0, 0, 32'h0,        32'h0,        0, 0, 0, 32'h0,        3'd0, 0, 0, 32'hDEADBEEF, 0, 32'h0,        4'h0, 32'h12345678);
        // write: response data must not reach rsp_o
        add(1, 1, 32'h00001000, 32'hCAFEF00D, 0, 0, 0, 32'h0,        3'd1, 1, 0, 32'h00001000, 1, 32'hCAFEF00D, 4'hF, 32'h12345678);
        add(0, 0, 32'h0,        32'h0,        1, 0, 0, 32'h0,        3'd2, 0, 1, 32'h00001000, 1, 32'hCAFEF00D, 4'hF, 32'h12345678);
        add(0, 0, 32'h0,        32'h0,        0, 1, 0, 32'h55555555, 3'd3, 0, 0, 32'h00001000, 1, 32'hCAFEF00D, 4'h0, 32'h12345678);
        add(0, 0, 32'h0,        32'h0,        0, 0, 0, 32'h0,        3'd0, 0, 0, 32'h00001000, 1, 32'hCAFEF00D, 4'h0, 32'h12345678);
        // grant stall with changing controller inputs; rvalid in ADDR ignored
        add(1, 0, 32'h000000A0, 32'h0,        0, 0, 0, 32'h0,        3'd1, 1, 0, 32'h000000A0, 0, 32'h0,        4'hF, 32'h12345678);
        add(1, 1, 32'hBBBB0000, 32'h99,       0, 0, 0, 32'h0,        3'd1, 1, 0, 32'h000000A0, 0, 32'h0,        4'hF, 32'h12345678);
        add(0, 0, 32'h11110000, 32'h0,        0, 1, 0, 32'h66666666, 3'd1, 1, 0, 32'h000000A0, 0, 32'h0,        4'hF, 32'h12345678);
        add(1, 0, 32'h22220000, 32'h0,        0, 0, 0, 32'h0,        3'd1, 1, 0, 32'h000000A0, 0, 32'h0,        4'hF, 32'h12345678);
        add(1, 0, 32'h22220000, 32'h0,        1, 0, 0, 32'h0,        3'd2, 0, 1, 32'h000000A0, 0, 32'h0,        4'hF, 32'h12345678);
        add(1, 0, 32'h22220000, 32'h0,        0, 1, 0, 32'h0BADF00D, 3'd3, 0, 0, 32'h000000A0, 0, 32'h0,        4'h0, 32'h0BADF00D);
        // DONE ignores req; the following IDLE edge re-arms
        add(1, 0, 32'h33330000, 32'h0,        0, 0, 0, 32'h0,        3'd0, 0, 0, 32'h000000A0, 0, 32'h0,        4'h0, 32'h0BADF00D);
        add(1, 0, 32'h33330000, 32'h0,        0, 0, 0, 32'h0,        3'd1, 1, 0, 32'h33330000, 0, 32'h0,        4'hF, 32'h0BADF00D);
        add(0, 0, 32'h0,        32'h0,        1, 0, 0, 32'h0,        3'd2, 0, 1, 32'h33330000, 0, 32'h0,        4'hF, 32'h0BADF00D);
        // wait in RESP, then an error response
        add(0, 0, 32'h0,        32'h0,        1, 0, 0, 32'h0,        3'd2, 0, 1, 32'h33330000, 0, 32'h0,        4'hF, 32'h0BADF00D);
        add(0, 0, 32'h0,        32'h0,        0, 1, 1, 32'h77777777, exp_err_st, 0, 0, 32'h33330000, 0, 32'h0,  4'h0, exp_err_rsp);
        add(0, 0, 32'h0,        32'h0,        0, 0, 0, 32'h0,        3'd0, 0, 0, 32'h33330000, 0, 32'h0,        4'h0, exp_err_rsp);

        drive(0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
        reset_ni = 1'b1;
        #1 reset_ni = 1'b0;
        #5 reset_ni = 1'b1;
        #1;
        chk_reset_vals("por");

        foreach (vecs[i]) begin
            drive(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                  vecs[i].gnt, vecs[i].rvalid, vecs[i].err, vecs[i].rdata);
            tick();
            chk($sformatf("v%0d state", i),  {29'd0, dut.state},     {29'd0, vecs[i].st});
            chk($sformatf("v%0d req", i),    {31'd0, obi_req_o},     {31'd0, vecs[i].oreq});
            chk($sformatf("v%0d rready", i), {31'd0, obi_rready_o},  {31'd0, vecs[i].ordy});
            chk($sformatf("v%0d addr", i),   obi_addr_o,             vecs[i].oaddr);
            chk($sformatf("v%0d we", i),     {31'd0, obi_we_o},      {31'd0, vecs[i].owe});
            chk($sformatf("v%0d wdata", i),  obi_wdata_o,            vecs[i].owdata);
            chk($sformatf("v%0d be", i),     {28'd0, obi_be_o},      {28'd0, vecs[i].obe});
            chk($sformatf("v%0d rsp", i),    rsp_o,                  vecs[i].orsp);
        end

        // asynchronous reset while in RESP, no retry afterwards
        drive(1, 1, 32'h44440000, 32'h12121212, 0, 0, 0, 32'h0);
        tick();
        drive(0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h0);
        tick();
        chk("mid pre state", {29'd0, dut.state}, 32'd2);
        drive(0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
        #2 reset_ni = 1'b0;
        #1;
        chk_reset_vals("mid");
        #1 reset_ni = 1'b1;
        tick();
        tick();
        chk("post state", {29'd0, dut.state}, 32'd0);
        chk("post req", {31'd0, obi_req_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/obi_mgr.md
Name: obi_mgr

Overview:
- Single-outstanding-transaction OBI (Open Bus Interface) manager.
- Takes one request at a time from a local controller: req_i, we_i, addr_i, wdata_i.
- Drives it onto the OBI A channel, waits for grant, then collects the R-channel response and returns read data on rsp_o.
- Sits between a simple core/controller and an OBI interconnect or subordinate.

Parameters:
- ADDR_WIDTH, 32, width of addr_i/obi_addr_o.
- DATA_WIDTH, 32, width of data buses; obi_be_o is DATA_WIDTH/8.
- AUSER_WIDTH, 0, A-channel user width; 0 = not implemented, no port.
- WUSER_WIDTH, 0, write user width; 0 = not implemented.
- RUSER_WIDTH, 0, R-channel user width; 0 = not implemented.
- ID_WIDTH, 0, transaction ID width; 0 = not implemented.
- ACHK_WIDTH, 0, A-channel integrity width; 0 = not implemented.
- RCHK_WIDTH, 0, R-channel integrity width; 0 = not implemented.
- COMB_GNT, 0, 1 = IDLE-cycle request/grant fast path allowed (see Behaviour).

Ports:
- clk_i  in  1  clock, rising edge.
- reset_ni  in  1  reset, asynchronous, active-low.
- req_i  in  1  controller transaction request.
- we_i  in  1  1=write, 0=read.
- addr_i  in  ADDR_WIDTH  transaction address.
- wdata_i  in  DATA_WIDTH  write data.
- rsp_o  out  DATA_WIDTH  read response data.
- obi_req_o  out  1  OBI A-channel request.
- obi_gnt_i  in  1  OBI grant.
- obi_addr_o  out  ADDR_WIDTH  OBI address.
- obi_we_o  out  1  OBI write enable.
- obi_be_o  out  DATA_WIDTH/8  OBI byte enables.
- obi_wdata_o  out  DATA_WIDTH  OBI write data.
- obi_rvalid_i  in  1  OBI response valid.
- obi_rready_o  out  1  OBI response ready.
- obi_rdata_i  in  DATA_WIDTH  OBI read data.
- obi_err_i  in  1  OBI response error.

Behaviour:
- One clock (clk_i); reset_ni asynchronous, active-low.
- State register is named `state`, 3 bits, internal and hierarchically visible.
- Encodings: IDLE=3'b000, ADDR=3'b001, RESP=3'b010, DONE=3'b011, ERR=3'b100 (ERR only with option).
- Reset values:
  - state=IDLE.
  - obi_req_o=0, obi_addr_o=0, obi_we_o=0, obi_wdata_o=0, obi_be_o=0.
  - obi_rready_o=0, rsp_o=0.
  - Reset asserted mid-transaction aborts the transaction immediately; no retry after release.
- IDLE:
  - obi_req_o=0, obi_rready_o=0.
  - If req_i=1 at a clock edge: latch addr_i, we_i, wdata_i into obi_addr_o, obi_we_o, obi_wdata_o; set obi_be_o to all ones; go to ADDR.
- ADDR:
  - obi_req_o=1.
  - addr/we/be/wdata held stable until the grant edge, per the OBI rule.
  - obi_gnt_i=1 at an edge: go to RESP, drop obi_req_o.
  - No grant: remain in ADDR indefinitely; req_i is ignored.
- RESP:
  - obi_rready_o=1.
  - obi_rvalid_i=1 at an edge: for reads, rsp_o <= obi_rdata_i; for writes, rsp_o unchanged. Go to DONE.
  - rvalid in the same cycle as grant is not possible (rvalid is sampled only in RESP).
- DONE:
  - One cycle; obi_rready_o=0, obi_be_o=0; return to IDLE.
  - req_i held high re-arms on the next IDLE edge. Throughput: one transaction per 4 cycles minimum.
- COMB_GNT=1:
  - In IDLE, obi_req_o=req_i combinationally, and obi_addr_o/obi_we_o/obi_wdata_o pass addr_i/we_i/wdata_i through.
  - If obi_gnt_i=1 in that cycle: go directly to RESP; addresses are latched.
  - Otherwise: go to ADDR as normal.
- obi_err_i: ignored unless the option is enabled; rsp_o still captures rdata.
- No further requests are accepted while state≠IDLE; one outstanding transaction maximum.
- Zero-width optional signal groups generate no ports and no logic.

Optional Feature:
- Macro: OBI_MGR_ERR_RESP_EN.
- Defined:
  - obi_rvalid_i=1 with obi_err_i=1 in RESP sets rsp_o to all ones (0xFFFFFFFF at 32 bits) for both reads and writes.
  - state goes to ERR (3'b100) for one cycle instead of DONE, then to IDLE.
- Undefined: obi_err_i is unused, ERR is unreachable, and normal DONE flow applies.

Test Plan:
- Power-on:
  - Stimulus: reset_ni pulsed low for 5 ns, all inputs 0.
  - Response: state==3'b000, obi_req_o=0, rsp_o=0.
- Read:
  - Stimulus: req_i=1, we_i=0, addr_i=0xDEADBEEF; grant one cycle later; rvalid next cycle with rdata=0x12345678.
  - Response: obi_addr_o=0xDEADBEEF and obi_be_o=4'hF while obi_req_o=1; rsp_o=0x12345678; state sequence 000→001→010→011→000.
- Write:
  - Stimulus: we_i=1, addr_i=0x00001000, wdata_i=0xCAFEF00D; grant; rvalid.
  - Response: obi_we_o=1, obi_wdata_o=0xCAFEF00D; rsp_o unchanged.
- Grant stall:
  - Stimulus: grant withheld 3 cycles while addr_i and req_i change.
  - Response: obi_req_o stays 1 and obi_addr_o stays at the latched value until the grant edge.
- Reset mid-transaction:
  - Stimulus: reset_ni low while in RESP.
  - Response: state=000 and all outputs at reset values immediately, without waiting for a clock edge.
- Error (OBI_MGR_ERR_RESP_EN defined):
  - Stimulus: obi_rvalid_i=1 with obi_err_i=1 on a read.
  - Response: rsp_o=0xFFFFFFFF; state visits 3'b100.
